// File: rtl/y86_fetch_if.sv
// Fetch-to-decode handshake plus the redirect path from later pipeline stages.
// The master side is the fetch stage; the slave side is decode/redirect logic.
interface y86_fetch_if #(
  parameter int PC_W = 64
);
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            out_ready;
  logic            out_valid;
  logic [PC_W-1:0] pc_out;
  logic [3:0]      icode;
  logic [3:0]      ifun;
  logic [3:0]      rA;
  logic [3:0]      rB;
  logic [PC_W-1:0] valC;
  logic [PC_W-1:0] valP;
  logic [2:0]      stat;

  modport master (
    input  redirect_valid, redirect_pc, out_ready,
    output out_valid, pc_out, icode, ifun, rA, rB, valC, valP, stat
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready,
    input  out_valid, pc_out, icode, ifun, rA, rB, valC, valP, stat
  );
endinterface

// File: rtl/y86_fetch_stage.sv
// Registered Y86-64 fetch stage: owns the PC and a byte-wide instruction memory,
// decodes one instruction per cycle and hands it to decode over valid/ready.
module y86_fetch_stage #(
  parameter int              IMEM_BYTES = 1024,
  parameter int              PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}},
  parameter int              AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           imem_we,
  input  logic [AW-1:0]  imem_waddr,
  input  logic [7:0]     imem_wdata,
  y86_fetch_if.master    fetch
);

  localparam logic [2:0]    STAT_AOK = 3'b001;
  localparam logic [2:0]    STAT_HLT = 3'b010;
  localparam logic [2:0]    STAT_ADR = 3'b011;
  localparam logic [2:0]    STAT_INS = 3'b100;
  localparam logic [PC_W:0] MEM_END  = (PC_W+1)'(IMEM_BYTES);

  function automatic logic f_has_regids(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: f_has_regids = 1'b1;
      default:                                  f_has_regids = 1'b0;
    endcase
  endfunction

  function automatic logic f_has_valc(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: f_has_valc = 1'b1;
      default:                      f_has_valc = 1'b0;
    endcase
  endfunction

  function automatic logic f_ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: f_ifun_ok = (fn == 4'h0);
      4'h2, 4'h7:                                           f_ifun_ok = (fn <= 4'h6);
      4'h6:                                                 f_ifun_ok = (fn <= 4'h3);
      default:                                              f_ifun_ok = 1'b0;
    endcase
  endfunction

  logic [7:0]      imem_r [IMEM_BYTES];
  logic [PC_W-1:0] pc_r;
  logic            halted_r;
  logic            out_valid_r;
  logic [PC_W-1:0] pc_out_r;
  logic [3:0]      icode_r, ifun_r, ra_r, rb_r;
  logic [PC_W-1:0] valc_r, valp_r;
  logic [2:0]      stat_r;

  logic [PC_W:0]   addr_s [10];
  logic [7:0]      byte_s [10];
  logic            has_reg_s, has_valc_s, pc_oor_s, end_oor_s;
  logic [3:0]      len_s;
  logic [PC_W:0]   last_s;
  logic [63:0]     valc_raw_s;
  logic [3:0]      icode_s, ifun_s, ra_s, rb_s;
  logic [PC_W-1:0] valc_s, valp_s;
  logic [2:0]      stat_s;
  logic            load_s;

  // Program loader write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  // Gather the up-to-ten instruction bytes at pc_r; bytes past the end read as zero.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      addr_s[i] = {1'b0, pc_r} + (PC_W+1)'(i);
      if (addr_s[i] < MEM_END) begin
        byte_s[i] = imem_r[addr_s[i][AW-1:0]];
      end else begin
        byte_s[i] = 8'h00;
      end
    end
  end

  // Decode fields, length, status and fall-through PC of the instruction at pc_r.
  always_comb begin
    has_reg_s  = f_has_regids(byte_s[0][7:4]);
    has_valc_s = f_has_valc(byte_s[0][7:4]);
    len_s      = 4'd1 + (has_reg_s ? 4'd1 : 4'd0) + (has_valc_s ? 4'd8 : 4'd0);
    pc_oor_s   = ({1'b0, pc_r} >= MEM_END);
    last_s     = {1'b0, pc_r} + (PC_W+1)'(len_s) - {{PC_W{1'b0}}, 1'b1};
    end_oor_s  = (last_s >= MEM_END);
    for (int j = 0; j < 8; j++) begin
      valc_raw_s[8*j +: 8] = has_reg_s ? byte_s[j+2] : byte_s[j+1];
    end
    icode_s = byte_s[0][7:4];
    ifun_s  = byte_s[0][3:0];
    ra_s    = has_reg_s ? byte_s[1][7:4] : 4'hF;
    rb_s    = has_reg_s ? byte_s[1][3:0] : 4'hF;
    valc_s  = has_valc_s ? valc_raw_s[PC_W-1:0] : {PC_W{1'b0}};
    valp_s  = pc_r;
    stat_s  = STAT_AOK;
    if (pc_oor_s) begin
      // Nothing fetchable: present a nop-shaped record carrying the address error.
      icode_s = 4'h1;
      ifun_s  = 4'h0;
      ra_s    = 4'hF;
      rb_s    = 4'hF;
      valc_s  = {PC_W{1'b0}};
      stat_s  = STAT_ADR;
    end else if (end_oor_s) begin
      stat_s  = STAT_ADR;
    end else if (!f_ifun_ok(icode_s, ifun_s)) begin
      stat_s  = STAT_INS;
    end else if (icode_s == 4'h0) begin
      stat_s  = STAT_HLT;
      valp_s  = pc_r + PC_W'(len_s);
    end else begin
      stat_s  = STAT_AOK;
      valp_s  = pc_r + PC_W'(len_s);
    end
  end

  assign load_s = !halted_r && (!out_valid_r || fetch.out_ready) && !fetch.redirect_valid;

  // PC, halt flag and output register; reset beats redirect, redirect beats load/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      halted_r    <= 1'b0;
      out_valid_r <= 1'b0;
      pc_out_r    <= {PC_W{1'b0}};
      icode_r     <= 4'h0;
      ifun_r      <= 4'h0;
      ra_r        <= 4'hF;
      rb_r        <= 4'hF;
      valc_r      <= {PC_W{1'b0}};
      valp_r      <= {PC_W{1'b0}};
      stat_r      <= STAT_AOK;
    end else if (fetch.redirect_valid) begin
      pc_r        <= fetch.redirect_pc;
      halted_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      pc_r        <= valp_s;
      halted_r    <= (stat_s != STAT_AOK);
      out_valid_r <= 1'b1;
      pc_out_r    <= pc_r;
      icode_r     <= icode_s;
      ifun_r      <= ifun_s;
      ra_r        <= ra_s;
      rb_r        <= rb_s;
      valc_r      <= valc_s;
      valp_r      <= valp_s;
      stat_r      <= stat_s;
    end else if (out_valid_r && fetch.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign fetch.out_valid = out_valid_r;
  assign fetch.pc_out    = pc_out_r;
  assign fetch.icode     = icode_r;
  assign fetch.ifun      = ifun_r;
  assign fetch.rA        = ra_r;
  assign fetch.rB        = rb_r;
  assign fetch.valC      = valc_r;
  assign fetch.valP      = valp_r;
  assign fetch.stat      = stat_r;

endmodule

// File: doc/y86_fetch_stage.md
# y86_fetch_stage

Parametrised, registered Y86-64 fetch stage with a byte-addressed instruction memory of configurable depth. It owns the program counter and decodes the icode/ifun, register, and constant fields. It computes valP and a 3-bit status, then presents one fetched instruction per cycle to decode through a valid/ready handshake. It also accepts PC redirects from later stages (taken jump, call, ret, mispredict). It sits between the program loader and the decode stage of the SEQ/pipelined core.

## Interface
Parameters:
- IMEM_BYTES, 1024, instruction memory depth in bytes (power of two not required).
- PC_W, 64, PC/valC/valP width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; every state change happens on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_we  in  1  byte write enable for loading the program.
- imem_waddr  in  $clog2(IMEM_BYTES)  write byte address.
- imem_wdata  in  8  write byte.
- redirect_valid  in  1  load redirect_pc as the next fetch PC and flush the output register.
- redirect_pc  in  PC_W  redirect target.
- out_ready  in  1  decode accepts the current output this cycle.
- out_valid  out  1  the output register holds a fetched instruction.
- pc_out  out  PC_W  address of the presented instruction.
- icode, ifun, rA, rB  out  4 each  decoded fields.
- valC  out  PC_W  constant word, little-endian.
- valP  out  PC_W  fall-through PC.
- stat  out  3  status: AOK=001, HLT=010, ADR=011, INS=100.

## Operation
- Internal state: pc_reg, halted flag, output register (out_valid plus all out fields), and a byte array imem[IMEM_BYTES].
- Instruction layout:
  - byte0 = {icode[7:4], ifun[3:0]}.
  - byte1 = {rA[7:4], rB[3:0]}.
  - valC is the 8 bytes following the last header byte; the lowest address is the LSB.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes (regids).
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes (regids + valC).
  - 7 jXX, 8 call: 9 bytes (valC at PC+1..PC+8).
- Field defaults: if the instruction has no regids, rA = rB = 4'hF. If it has no valC, valC = 0.
- Validity rules:
  - ifun must be 0 for icodes 0, 1, 3, 4, 5, 8, 9, A, B.
  - ifun must be 0–6 for icodes 2 and 7.
  - ifun must be 0–3 for icode 6.
  - icode > 4'hB is invalid.
- Status priority is ADR > INS > HLT > AOK:
  - ADR: pc_reg ≥ IMEM_BYTES, or pc_reg + length − 1 ≥ IMEM_BYTES. If pc_reg itself is out of range, report icode = 1, ifun = 0.
  - INS: any validity rule is violated.
  - HLT: icode = 0.
- valP:
  - valP = pc_reg + length for AOK and HLT.
  - valP = pc_reg for ADR and INS.
  - The addition wraps modulo 2^PC_W.
- Load condition: load = !halted && (!out_valid || out_ready) && !redirect_valid.
  - On load, the output register captures the decode of pc_reg, out_valid goes to 1, and pc_reg takes valP.
  - If the captured stat ≠ AOK, halted sets; no further loads happen until reset or redirect.
- If out_valid && out_ready && no load (halted), out_valid goes to 0.
- Stall: out_valid && !out_ready holds every output and pc_reg unchanged.
- Redirect (priority over load and stall; reset has priority over redirect):
  - pc_reg takes redirect_pc, out_valid goes to 0, halted clears.
  - The flushed instruction is discarded even if out_ready = 1 in the same cycle.
- Memory writes:
  - Write on imem_we at the edge.
  - A fetch in the same cycle that covers the written byte sees the old data.
  - Writes are legal while halted and while fetching.

## Timing
- Reset values:
  - pc_reg = RESET_PC, halted = 0, out_valid = 0.
  - pc_out, icode, ifun, valC, valP = 0.
  - rA = rB = 4'hF, stat = 001.
  - imem contents are not reset.
- Latency: the first instruction shows out_valid = 1 in the first cycle after the edge where rst is sampled low.
- After a redirect edge, the redirected instruction is valid one cycle later.
- Throughput: one instruction per cycle while out_ready = 1.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Program loading and sequential fetch:
  - Load 30 F3 + 0x0123456789ABCDEF (LE) at 0, then 60 23 at 10, then 00 at 12; hold out_ready = 1.
  - Expect three consecutive valid cycles:
    - icode 3, rA F, rB 3, valC 0x0123456789ABCDEF, valP 10.
    - icode 6, ifun 0, rA 2, rB 3, valP 12.
    - icode 0, stat 010, valP 13.
  - Then out_valid = 0 for the rest of the run.
- Stall: drop out_ready for 3 cycles while an instruction is presented. Expect all outputs constant; when out_ready returns, the next instruction follows with no skip or duplicate.
- Invalid instruction: byte C0 at PC 0. Expect stat 100, valP 0, halted. Separately, 6 4 (OPq ifun 4) gives stat 100.
- Address error, with IMEM_BYTES = 16:
  - jXX at PC 8 (needs bytes 8–16): stat 011, valP 8.
  - redirect_pc = 20: stat 011, icode 1.
- Redirect:
  - Redirect to 0x40 while halted: fetch resumes, the next output has pc_out 0x40.
  - Redirect together with out_ready = 1: the old output is dropped, with one bubble cycle.
  - Redirect in the same cycle as rst: pc_reg = RESET_PC.
- Reset mid-run: assert rst during a stall. The next cycle shows out_valid = 0, stat 001, rA/rB F, and fetch restarts at RESET_PC.
